// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction decode path: default field widths,
// field positions and the opcode encoding used by the decode queue and the control unit.
package isa_pkg;

    localparam int INSTR_W = 8;
    localparam int OP_W    = 3;
    localparam int RS_W    = 2;

    // Field positions within a default-width instruction word (low field overlaps Rs)
    localparam int OP_MSB  = INSTR_W - 1;
    localparam int OP_LSB  = INSTR_W - OP_W;
    localparam int RS_MSB  = OP_LSB - 1;
    localparam int RS_LSB  = OP_LSB - RS_W;
    localparam int LOW_MSB = OP_LSB - 1;
    localparam int LOW_W   = OP_LSB;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_AND   = 3'd4,
        OP_OR    = 3'd5,
        OP_BEQ   = 3'd6,
        OP_JMP   = 3'd7
    } opcode_e;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of one instruction word into opcode, Rs and low field,
// plus extension of the low field back to the full word width.
module instr_field_split
    import isa_pkg::*;
#(
    parameter int INSTR_W  = isa_pkg::INSTR_W,
    parameter int OP_W     = isa_pkg::OP_W,
    parameter int RS_W     = isa_pkg::RS_W,
    parameter int SIGN_EXT = 0
) (
    input  logic [INSTR_W-1:0]      word,
    output logic [OP_W-1:0]         opcode,
    output logic [RS_W-1:0]         rs,
    output logic [INSTR_W-OP_W-1:0] low,
    output logic [INSTR_W-1:0]      imm_ext
);

    localparam int LW = INSTR_W - OP_W;

    logic fill_s;

    // Field extraction and extension; Rs is a sub-range of the low field
    always_comb begin
        opcode = word[INSTR_W-1 -: OP_W];
        rs     = word[LW-1 -: RS_W];
        low    = word[LW-1:0];
        if (SIGN_EXT != 0) begin
            fill_s = word[LW-1];
        end else begin
            fill_s = 1'b0;
        end
        imm_ext = {{OP_W{fill_s}}, word[LW-1:0]};
    end

endmodule

// File: rtl/instr_decode_queue.sv
// DEPTH-entry instruction FIFO between fetch and control, with flush for branches;
// the head entry is decoded combinationally into its instruction fields.
module instr_decode_queue
    import isa_pkg::*;
#(
    parameter int INSTR_W  = isa_pkg::INSTR_W,
    parameter int OP_W     = isa_pkg::OP_W,
    parameter int RS_W     = isa_pkg::RS_W,
    parameter int DEPTH    = 4,
    parameter int SIGN_EXT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [INSTR_W-1:0]        in_instr,
    output logic                      in_ready,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OP_W-1:0]           out_opcode,
    output logic [RS_W-1:0]           out_rs,
    output logic [INSTR_W-OP_W-1:0]   out_low,
    output logic [INSTR_W-1:0]        out_imm_ext,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (OP_W + RS_W >= INSTR_W) begin : g_bad_widths
        $error("instr_decode_queue: OP_W + RS_W must be less than INSTR_W");
    end

    logic [INSTR_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic               push_s;
    logic               pop_s;

    // Handshake qualification; flush wins over both directions
    always_comb begin
        in_ready  = (count_r != CNT_W'(DEPTH));
        out_valid = (count_r != {CNT_W{1'b0}});
        push_s    = in_valid && in_ready && !flush;
        pop_s     = out_valid && out_ready && !flush;
        count     = count_r;
    end

    // Occupancy update for the four push/pop combinations
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            2'b11:   count_next_s = count_r;
            2'b00:   count_next_s = count_r;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers and count; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Instruction storage, cleared on reset so the decoded fields read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= in_instr;
        end
    end

    instr_field_split #(
        .INSTR_W  (INSTR_W),
        .OP_W     (OP_W),
        .RS_W     (RS_W),
        .SIGN_EXT (SIGN_EXT)
    ) u_split (
        .word    (mem_r[rd_ptr_r]),
        .opcode  (out_opcode),
        .rs      (out_rs),
        .low     (out_low),
        .imm_ext (out_imm_ext)
    );

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: two instances (zero- and sign-extending)
// share one stimulus stream; a reference queue checks a randomised traffic phase.
module tb_instr_decode_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_instr;
    logic       flush;
    logic       out_ready;

    logic       in_ready, out_valid;
    logic [2:0] out_opcode;
    logic [1:0] out_rs;
    logic [4:0] out_low;
    logic [7:0] out_imm_ext;
    logic [2:0] count;

    logic       in_ready_s1, out_valid_s1;
    logic [2:0] out_opcode_s1;
    logic [1:0] out_rs_s1;
    logic [4:0] out_low_s1;
    logic [7:0] out_imm_ext_s1;
    logic [2:0] count_s1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_decode_queue #(.INSTR_W(8), .OP_W(3), .RS_W(2), .DEPTH(4), .SIGN_EXT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_low(out_low),
        .out_imm_ext(out_imm_ext), .count(count)
    );

    instr_decode_queue #(.INSTR_W(8), .OP_W(3), .RS_W(2), .DEPTH(4), .SIGN_EXT(1)) dut_sx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready_s1), .flush(flush), .out_valid(out_valid_s1), .out_ready(out_ready),
        .out_opcode(out_opcode_s1), .out_rs(out_rs_s1), .out_low(out_low_s1),
        .out_imm_ext(out_imm_ext_s1), .count(count_s1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        in_valid = 1'b1;
        in_instr = w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] w);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_word"}, 32'({out_opcode, out_low}), 32'(w));
    endtask

    logic [7:0] q[$];
    logic [7:0] seq_w;
    logic [7:0] exp_w;
    logic       do_push, do_pop;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 8'h00; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fields", 32'({out_opcode, out_rs, out_low, out_imm_ext}), 32'd0);

        // Single push of 0xB5: opcode 5, rs 2, low 0x15, imm 0x15 / 0xF5
        push(8'hB5);
        check("b5_valid", 32'(out_valid), 32'd1);
        check("b5_opcode", 32'(out_opcode), 32'd5);
        check("b5_rs", 32'(out_rs), 32'd2);
        check("b5_low", 32'(out_low), 32'h15);
        check("b5_imm_zx", 32'(out_imm_ext), 32'h15);
        check("b5_imm_sx", 32'(out_imm_ext_s1), 32'hF5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("b5_popped", 32'(out_valid), 32'd0);

        // Fill to full, drop a fifth push, then drain in order
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        push(8'h55);
        check("full_drop_count", 32'(count), 32'd4);
        check("head_11_opc", 32'(out_opcode), 32'd0);
        check_head("head_11", 8'h11);
        in_valid = 1'b1; in_instr = 8'h66; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("full_pop_nopush", 32'(count), 32'd3);
        check("head_22_opc", 32'(out_opcode), 32'd1);
        check_head("head_22", 8'h22);
        step();
        check("head_33_opc", 32'(out_opcode), 32'd1);
        check_head("head_33", 8'h33);
        step();
        check("head_44_opc", 32'(out_opcode), 32'd2);
        check_head("head_44", 8'h44);
        step();
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_count", 32'(count), 32'd0);
        step();
        check("empty_pop_ignored", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Streaming push+pop at occupancy 2 across two pointer wraps
        q.delete();
        push(8'hA0); q.push_back(8'hA0);
        push(8'hC1); q.push_back(8'hC1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            seq_w = 8'h30 + 8'(i * 23);
            exp_w = q.pop_front();
            check_head("stream_head", exp_w);
            in_valid = 1'b1; in_instr = seq_w; q.push_back(seq_w);
            step();
            check("stream_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_head("stream_tail0", q[0]);

        // Flush at count 3 with simultaneous push and pop
        push(8'h77);
        check("pre_flush_count", 32'(count), 32'd3);
        in_valid = 1'b1; in_instr = 8'hEE; out_ready = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        push(8'h5A);
        check("post_flush_count", 32'(count), 32'd1);
        check_head("post_flush_head", 8'h5A);

        // Asynchronous reset between edges with two entries held
        push(8'h9C);
        check("pre_rst_count", 32'(count), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_fields", 32'({out_opcode, out_low}), 32'd0);
        #2 rst_n = 1'b1;
        step();

        // Random traffic against a reference queue
        q.delete();
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_instr  = 8'($urandom);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            #1;
            check("rnd_count", 32'(count), 32'(q.size()));
            check("rnd_bound", 32'(count <= 3'd4), 32'd1);
            check("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("rnd_in_ready", 32'(in_ready), 32'(q.size() != 4));
            if (q.size() != 0) begin
                check("rnd_head", 32'({out_opcode, out_low}), 32'(q[0]));
            end
            do_push = in_valid && (q.size() < 4) && !flush;
            do_pop  = out_ready && (q.size() > 0) && !flush;
            @(posedge clk);
            #1;
            if (flush) begin
                q.delete();
            end else begin
                if (do_pop) begin
                    void'(q.pop_front());
                end
                if (do_push) begin
                    q.push_back(in_instr);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
